pll_reset_sequencer: RTL and testbench



---
 rtl/didactic_rst_pkg.sv | 18 +
 rtl/btn_debounce.sv | 43 ++++
 rtl/pll_reset_sequencer.sv | 109 ++++++++++
 tb/tb_pll_reset_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/didactic_rst_pkg.sv
// Shared types for the SoC reset sequencer: FSM state encoding and counter sizing helper.
package didactic_rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STABLE  = 2'd1,
    STRETCH = 2'd2,
    RUN     = 2'd3
  } rst_state_e;

  localparam int LOCK_LOSS_W = 8;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Board reset button synchronizer plus debouncer: the level is accepted only after it
// has been held for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
  import didactic_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn_async,
  output logic btn_db
);

  localparam int             DW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0]          cnt;
  logic                   btn_s;

  assign btn_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync   <= '0;
      cnt    <= '0;
      btn_db <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_async};
      // Any cycle agreeing with the accepted level restarts the hold timer.
      if (btn_s == btn_db) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        btn_db <= btn_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the SoC core in reset until the PLL has been locked and stable, then releases it
// after a minimum-width stretch; lock loss or a debounced button press re-asserts reset.
module pll_reset_sequencer
  import didactic_rst_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_MIN_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES    = 8000
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   ext_rst_btn,
  output logic                   soc_rst,
  output logic                   ready,
  output logic [LOCK_LOSS_W-1:0] lock_loss_cnt,
  output logic [1:0]             state_o
);

  localparam int            CW          = cnt_w((LOCK_STABLE_CYCLES > RST_MIN_CYCLES) ?
                                                LOCK_STABLE_CYCLES : RST_MIN_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(RST_MIN_CYCLES - 1);

  rst_state_e             state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   locked_s;
  logic                   btn_db;

  assign locked_s = lock_sync[SYNC_STAGES-1];
  assign state_o  = state;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_in   (clk_in),
    .reset    (reset),
    .btn_async(ext_rst_btn),
    .btn_db   (btn_db)
  );

  always_ff @(posedge clk_in) begin
    if (reset) lock_sync <= '0;
    else       lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
  end

  // soc_rst/ready are loaded alongside every state change so they never lag the state.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state         <= HOLD;
      cnt           <= '0;
      soc_rst       <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state <= HOLD;
          end else if (cnt == STABLE_LAST) begin
            state <= STRETCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STRETCH: begin
          if (!locked_s) begin
            state <= HOLD;
          end else if (cnt != STRETCH_LAST) begin
            cnt <= cnt + 1'b1;
          end else if (!btn_db) begin
            state   <= RUN;
            soc_rst <= 1'b0;
            ready   <= 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state   <= HOLD;
            soc_rst <= 1'b1;
            ready   <= 1'b0;
            if (lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + 1'b1;
          end else if (btn_db) begin
            state   <= STRETCH;
            cnt     <= '0;
            soc_rst <= 1'b1;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= HOLD;
          soc_rst <= 1'b1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: scripted segment table with hand-derived end states,
// a 300-loss saturation run and random stimulus, all checked each cycle against a model.
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int LSC  = 8;
  localparam int RMC  = 4;
  localparam int DEB  = 5;

  logic       clk = 1'b0;
  logic       reset, pll_locked, ext_rst_btn;
  logic       soc_rst, ready;
  logic [7:0] lock_loss_cnt;
  logic [1:0] state_o;

  int n_chk = 0;
  int n_fail = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(LSC),
    .RST_MIN_CYCLES    (RMC),
    .DEBOUNCE_CYCLES   (DEB)
  ) dut (
    .clk_in       (clk),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .ext_rst_btn  (ext_rst_btn),
    .soc_rst      (soc_rst),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Behavioural reference: delay lines for the synchronizers, a hold-run length for the
  // button, and a phase with its age in cycles (0 HOLD, 1 STABLE, 2 STRETCH, 3 RUN).
  int m_st, m_age, m_loss, m_run;
  bit m_db;
  bit m_lq[$];
  bit m_bq[$];

  task automatic m_reset();
    m_st = 0; m_age = 0; m_loss = 0; m_run = 0; m_db = 0;
    m_lq.delete(); m_bq.delete();
    for (int i = 0; i < SYNC; i++) begin
      m_lq.push_back(1'b0);
      m_bq.push_back(1'b0);
    end
  endtask

  task automatic m_edge(input bit l, input bit b, input bit r);
    bit ls, bs, bd;
    if (r) begin
      m_reset();
      return;
    end
    ls = m_lq[SYNC-1];
    bs = m_bq[SYNC-1];
    bd = m_db;
    m_lq.push_front(l); void'(m_lq.pop_back());
    m_bq.push_front(b); void'(m_bq.pop_back());
    if (bs != m_db) begin
      m_run++;
      if (m_run == DEB) begin m_db = bs; m_run = 0; end
    end else m_run = 0;
    case (m_st)
      0: if (ls) begin m_st = 1; m_age = 0; end
      1: if (!ls) m_st = 0;
         else begin
           m_age++;
           if (m_age == LSC) begin m_st = 2; m_age = 0; end
         end
      2: if (!ls) m_st = 0;
         else begin
           m_age++;
           if (m_age >= RMC && !bd) m_st = 3;
         end
      default: if (!ls) begin
                 m_st = 0;
                 if (m_loss < 255) m_loss++;
               end else if (bd) begin m_st = 2; m_age = 0; end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step(input bit l, input bit b, input bit r);
    pll_locked = l; ext_rst_btn = b; reset = r;
    m_edge(l, b, r);
    @(posedge clk);
    @(negedge clk);
    chk("model_soc_rst", {31'd0, soc_rst}, (m_st != 3) ? 1 : 0);
    chk("model_ready",   {31'd0, ready},   (m_st == 3) ? 1 : 0);
    chk("model_state",   {30'd0, state_o}, m_st);
    chk("model_loss",    {24'd0, lock_loss_cnt}, m_loss);
  endtask

  typedef struct {
    int n;
    bit lock, btn, rst;
    int e_st;
    bit e_rst, e_rdy;
    int e_loss;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset = 1'b1; pll_locked = 1'b0; ext_rst_btn = 1'b0;
    m_reset();

    //            n  lk bt rs  st rst rdy loss
    tbl.push_back('{ 3, 0, 0, 1, 0, 1, 0, 0});  // power-up reset
    tbl.push_back('{50, 0, 0, 0, 0, 1, 0, 0});  // unlocked: stays in HOLD
    tbl.push_back('{14, 1, 0, 0, 2, 1, 0, 0});  // clean lock, one edge before release
    tbl.push_back('{ 1, 1, 0, 0, 3, 0, 1, 0});  // release at exactly 15
    tbl.push_back('{ 2, 0, 0, 0, 3, 0, 1, 0});  // lock loss still in sync pipe
    tbl.push_back('{ 1, 0, 0, 0, 0, 1, 0, 1});  // reset after 3 cycles
    tbl.push_back('{ 5, 1, 0, 0, 1, 1, 0, 1});  // chatter: high 5
    tbl.push_back('{ 3, 0, 0, 0, 0, 1, 0, 1});  // low 3 -> back to HOLD, no count
    tbl.push_back('{14, 1, 0, 0, 2, 1, 0, 1});
    tbl.push_back('{ 1, 1, 0, 0, 3, 0, 1, 1});  // 15 after final rise
    tbl.push_back('{ 3, 1, 1, 0, 3, 0, 1, 1});  // 3-cycle button pulse
    tbl.push_back('{10, 1, 0, 0, 3, 0, 1, 1});  // rejected
    tbl.push_back('{ 5, 1, 1, 0, 3, 0, 1, 1});  // 5-cycle clean press
    tbl.push_back('{ 2, 1, 0, 0, 3, 0, 1, 1});
    tbl.push_back('{ 1, 1, 0, 0, 2, 1, 0, 1});  // reset 8 cycles after press
    tbl.push_back('{ 4, 1, 0, 0, 2, 1, 0, 1});  // waiting for debounced release
    tbl.push_back('{ 1, 1, 0, 0, 3, 0, 1, 1});
    tbl.push_back('{20, 1, 1, 0, 2, 1, 0, 1});  // held button keeps reset
    tbl.push_back('{ 7, 1, 0, 0, 2, 1, 0, 1});
    tbl.push_back('{ 1, 1, 0, 0, 3, 0, 1, 1});  // resumes after debounced release
    tbl.push_back('{ 5, 0, 1, 0, 0, 1, 0, 2});  // button + lock loss together
    tbl.push_back('{10, 0, 0, 0, 0, 1, 0, 2});
    tbl.push_back('{ 5, 1, 0, 0, 1, 1, 0, 2});  // into STABLE
    tbl.push_back('{ 1, 1, 0, 1, 0, 1, 0, 0});  // sync reset mid-STABLE
    tbl.push_back('{14, 1, 0, 0, 2, 1, 0, 0});
    tbl.push_back('{ 1, 1, 0, 0, 3, 0, 1, 0});

    foreach (tbl[k]) begin
      for (int c = 0; c < tbl[k].n; c++) step(tbl[k].lock, tbl[k].btn, tbl[k].rst);
      chk($sformatf("tbl%0d_state", k),   {30'd0, state_o}, tbl[k].e_st);
      chk($sformatf("tbl%0d_soc_rst", k), {31'd0, soc_rst}, {31'd0, tbl[k].e_rst});
      chk($sformatf("tbl%0d_ready", k),   {31'd0, ready},   {31'd0, tbl[k].e_rdy});
      chk($sformatf("tbl%0d_loss", k),    {24'd0, lock_loss_cnt}, tbl[k].e_loss);
    end

    // 300 lock losses from RUN: counter must stick at 255.
    for (int i = 0; i < 300; i++) begin
      repeat (3)  step(1'b0, 1'b0, 1'b0);
      repeat (15) step(1'b1, 1'b0, 1'b0);
    end
    chk("sat_state", {30'd0, state_o}, 3);
    chk("sat_loss",  {24'd0, lock_loss_cnt}, 255);

    // Random lock/button activity with occasional block reset.
    begin
      bit l, b, r;
      l = 1'b1; b = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(39, 0) == 0) l = ~l;
        if ($urandom_range(11, 0) == 0) b = ~b;
        r = ($urandom_range(499, 0) == 0);
        step(l, b, r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
